// File: rtl/naive_arb_pkg.sv
// Shared types for the two-master naive_bus arbiter: master ids, arbiter FSM states and the
// hold-counter width helper.
package naive_arb_pkg;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Bits needed to count 0..hold_max consecutive beats.
    function automatic int unsigned hold_w(input int unsigned hold_max);
        return $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/naive_arb_pick.sv
// Combinational owner selection for naive_bus_arb2.
// NAIVE_ARB2_FIXED_PRIO_EN selects strict m0 priority instead of bounded round-robin.
module naive_arb_pick
    import naive_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned HW       = hold_w(HOLD_MAX)
) (
    input  state_t          state,
    input  arb_id_t         rr_ptr,
    input  logic [HW-1:0]   hold_cnt,
    input  logic            req0,
    input  logic            req1,
    output arb_id_t         owner
);

`ifdef NAIVE_ARB2_FIXED_PRIO_EN
    always_comb begin
        owner = ARB_NONE;
        if (req0) begin
            owner = ARB_M0;
        end else if (req1) begin
            owner = ARB_M1;
        end
    end
`else
    logic below_max;

    assign below_max = hold_cnt < HW'(HOLD_MAX);

    always_comb begin
        owner = ARB_NONE;
        case (state)
            IDLE: begin
                if (rr_ptr == ARB_M1) begin
                    if (req1)      owner = ARB_M1;
                    else if (req0) owner = ARB_M0;
                end else begin
                    if (req0)      owner = ARB_M0;
                    else if (req1) owner = ARB_M1;
                end
            end
            OWN0: begin
                if (req0 && (below_max || !req1)) owner = ARB_M0;
                else if (req1)                    owner = ARB_M1;
            end
            OWN1: begin
                if (req1 && (below_max || !req0)) owner = ARB_M1;
                else if (req0)                    owner = ARB_M0;
            end
            default: owner = ARB_NONE;
        endcase
    end
`endif

endmodule

// File: rtl/naive_bus_arb2.sv
// Two-master to one-slave naive_bus arbiter with read-response routing.
// NAIVE_ARB2_FIXED_PRIO_EN: m0 strict priority, no round-robin pointer or hold counter.
module naive_bus_arb2
    import naive_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_rd_req,
    input  logic        m0_wr_req,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wr_data,
    output logic        m0_rd_gnt,
    output logic        m0_wr_gnt,
    output logic [31:0] m0_rd_data,
    input  logic        m1_rd_req,
    input  logic        m1_wr_req,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wr_data,
    output logic        m1_rd_gnt,
    output logic        m1_wr_gnt,
    output logic [31:0] m1_rd_data,
    output logic        s_rd_req,
    output logic        s_wr_req,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wr_data,
    input  logic        s_rd_gnt,
    input  logic        s_wr_gnt,
    input  logic [31:0] s_rd_data
);

    localparam int unsigned HW = hold_w(HOLD_MAX);

    state_t        state_q, state_d;
    arb_id_t       rr_ptr_q;
    logic [HW-1:0] hold_cnt_q;
    arb_id_t       rd_sel_q, rd_sel_d;
    arb_id_t       owner;
    logic          req0, req1, acc;

    assign req0 = m0_rd_req | m0_wr_req;
    assign req1 = m1_rd_req | m1_wr_req;
    assign acc  = (owner != ARB_NONE) & (s_rd_gnt | s_wr_gnt);

    naive_arb_pick #(
        .HOLD_MAX (HOLD_MAX),
        .HW       (HW)
    ) u_pick (
        .state    (state_q),
        .rr_ptr   (rr_ptr_q),
        .hold_cnt (hold_cnt_q),
        .req0     (req0),
        .req1     (req1),
        .owner    (owner)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_sel_q <= ARB_NONE;
        end else begin
            state_q  <= state_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // Next state: follow the owner whether or not the slave accepted this cycle.
    always_comb begin
        state_d = IDLE;
        if (owner == ARB_M0)      state_d = OWN0;
        else if (owner == ARB_M1) state_d = OWN1;
    end

`ifdef NAIVE_ARB2_FIXED_PRIO_EN
    assign rr_ptr_q   = ARB_M0;
    assign hold_cnt_q = '0;
`else
    arb_id_t       rr_ptr_d;
    logic [HW-1:0] hold_cnt_d;
    arb_id_t       state_owner;

    always_comb begin
        state_owner = ARB_NONE;
        if (state_q == OWN0)      state_owner = ARB_M0;
        else if (state_q == OWN1) state_owner = ARB_M1;
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        if (owner == ARB_NONE) begin
            hold_cnt_d = '0;
        end else if (acc) begin
            if (owner != state_owner) begin
                hold_cnt_d = HW'(1);
            end else if (hold_cnt_q < HW'(HOLD_MAX)) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
            rr_ptr_d = (owner == ARB_M0) ? ARB_M1 : ARB_M0;
        end else if (owner != state_owner) begin
            // New owner that has not landed a beat yet has used none of its budget.
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= ARB_M0;
            hold_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // Bus muxing and grant steering
    always_comb begin
        s_rd_req   = 1'b0;
        s_wr_req   = 1'b0;
        s_be       = '0;
        s_addr     = '0;
        s_wr_data  = '0;
        m0_rd_gnt  = 1'b0;
        m0_wr_gnt  = 1'b0;
        m1_rd_gnt  = 1'b0;
        m1_wr_gnt  = 1'b0;
        rd_sel_d   = ARB_NONE;
        case (owner)
            ARB_M0: begin
                s_rd_req  = m0_rd_req;
                s_wr_req  = m0_wr_req;
                s_be      = m0_be;
                s_addr    = m0_addr;
                s_wr_data = m0_wr_data;
                m0_rd_gnt = s_rd_gnt;
                m0_wr_gnt = s_wr_gnt;
                if (m0_rd_req && s_rd_gnt) rd_sel_d = ARB_M0;
            end
            ARB_M1: begin
                s_rd_req  = m1_rd_req;
                s_wr_req  = m1_wr_req;
                s_be      = m1_be;
                s_addr    = m1_addr;
                s_wr_data = m1_wr_data;
                m1_rd_gnt = s_rd_gnt;
                m1_wr_gnt = s_wr_gnt;
                if (m1_rd_req && s_rd_gnt) rd_sel_d = ARB_M1;
            end
            default: ;
        endcase
    end

    assign m0_rd_data = (rd_sel_q == ARB_M0) ? s_rd_data : '0;
    assign m1_rd_data = (rd_sel_q == ARB_M1) ? s_rd_data : '0;

endmodule

// File: tb/tb_naive_bus_arb2.sv
// Bench for naive_bus_arb2: directed scenarios plus random traffic against a behavioural model,
// with a 1-cycle ROM slave (word[i] = 0x1000_0000 + i).
module tb_naive_bus_arb2;

    localparam int HOLD_MAX = 4;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic [3:0]  gnt;   // {m0_rd, m0_wr, m1_rd, m1_wr}
        logic [31:0] d0;
        logic [31:0] d1;
        logic        srd;
        logic        swr;
        logic [3:0]  sbe;
        logic [31:0] saddr;
        logic [31:0] swdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_rd_req = 0, m0_wr_req = 0, m1_rd_req = 0, m1_wr_req = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic [31:0] m0_addr = 0, m0_wr_data = 0, m1_addr = 0, m1_wr_data = 0;
    logic        m0_rd_gnt, m0_wr_gnt, m1_rd_gnt, m1_wr_gnt;
    logic [31:0] m0_rd_data, m1_rd_data;
    logic        s_rd_req, s_wr_req;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wr_data;
    logic        s_rd_gnt = 1'b1, s_wr_gnt = 1'b1;
    logic [31:0] s_rd_data = 32'h0;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    // Behavioural model state: current owner (-1 none), beats in its run, next priority.
    int   cur = -1, run = 0, pri = 0;
    logic pend_v = 1'b0;
    int   pend_m = 0;
    logic [31:0] pend_d = 0;

    naive_bus_arb2 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_rd_req  (m0_rd_req),
        .m0_wr_req  (m0_wr_req),
        .m0_be      (m0_be),
        .m0_addr    (m0_addr),
        .m0_wr_data (m0_wr_data),
        .m0_rd_gnt  (m0_rd_gnt),
        .m0_wr_gnt  (m0_wr_gnt),
        .m0_rd_data (m0_rd_data),
        .m1_rd_req  (m1_rd_req),
        .m1_wr_req  (m1_wr_req),
        .m1_be      (m1_be),
        .m1_addr    (m1_addr),
        .m1_wr_data (m1_wr_data),
        .m1_rd_gnt  (m1_rd_gnt),
        .m1_wr_gnt  (m1_wr_gnt),
        .m1_rd_data (m1_rd_data),
        .s_rd_req   (s_rd_req),
        .s_wr_req   (s_wr_req),
        .s_be       (s_be),
        .s_addr     (s_addr),
        .s_wr_data  (s_wr_data),
        .s_rd_gnt   (s_rd_gnt),
        .s_wr_gnt   (s_wr_gnt),
        .s_rd_data  (s_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    // ROM slave: data valid the cycle after a granted read.
    always @(posedge clk) begin
        if (s_rd_req && s_rd_gnt) s_rd_data <= rom_word(s_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents grants, routed read data and slave-side request.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("gnts", {28'h0, m0_rd_gnt, m0_wr_gnt, m1_rd_gnt, m1_wr_gnt}, {28'h0, e.gnt});
            chk("m0_rd_data", m0_rd_data, e.d0);
            chk("m1_rd_data", m1_rd_data, e.d1);
            chk("s_req", {26'h0, s_rd_req, s_wr_req, s_be}, {26'h0, e.srd, e.swr, e.sbe});
            chk("s_addr", s_addr, e.saddr);
            chk("s_wr_data", s_wr_data, e.swdata);
        end
    end

    // One bus cycle: drive inputs after the edge, predict the outputs, queue the prediction.
    task automatic cyc(input logic r, input mreq_t q0, input mreq_t q1, input logic rg,
                       input logic wg);
        exp_t  e;
        mreq_t qo;
        logic  req0, req1;
        int    o;
        @(posedge clk);
        #1;
        rst = r;
        m0_rd_req = q0.rd; m0_wr_req = q0.wr; m0_be = q0.be;
        m0_addr = q0.addr; m0_wr_data = q0.wdata;
        m1_rd_req = q1.rd; m1_wr_req = q1.wr; m1_be = q1.be;
        m1_addr = q1.addr; m1_wr_data = q1.wdata;
        s_rd_gnt = rg; s_wr_gnt = wg;

        if (r) begin
            cur = -1; run = 0; pri = 0; pend_v = 1'b0;
        end
        req0 = q0.rd | q0.wr;
        req1 = q1.rd | q1.wr;
`ifdef NAIVE_ARB2_FIXED_PRIO_EN
        o = req0 ? 0 : (req1 ? 1 : -1);
`else
        if (req0 && req1) begin
            if (cur < 0)             o = pri;
            else if (run < HOLD_MAX) o = cur;
            else                     o = 1 - cur;
        end else if (req0) begin
            o = 0;
        end else if (req1) begin
            o = 1;
        end else begin
            o = -1;
        end
`endif
        e = '0;
        qo = (o == 1) ? q1 : q0;
        if (o == 0) e.gnt = {rg, wg, 2'b00};
        if (o == 1) e.gnt = {2'b00, rg, wg};
        if (o >= 0) begin
            e.srd = qo.rd; e.swr = qo.wr; e.sbe = qo.be;
            e.saddr = qo.addr; e.swdata = qo.wdata;
        end
        if (pend_v && pend_m == 0) e.d0 = pend_d;
        if (pend_v && pend_m == 1) e.d1 = pend_d;
        exp_q.push_back(e);

        pend_v = !r && (o >= 0) && qo.rd && rg;
        pend_m = o;
        pend_d = rom_word(qo.addr);
        if (!r) begin
            if (o < 0) begin
                run = 0;
            end else if (rg || wg) begin
                run = (o == cur) ? ((run < HOLD_MAX) ? run + 1 : run) : 1;
                pri = 1 - o;
            end else if (o != cur) begin
                run = 0;
            end
            cur = o;
        end
    endtask

    function automatic mreq_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        mreq_t q;
        q.rd = rd; q.wr = wr; q.addr = addr; q.wdata = wdata; q.be = be;
        return q;
    endfunction

    initial begin
        mreq_t idle;
        idle = '0;
        #2 rst = 1'b1;

        // Reset state with nothing requesting
        cyc(1'b1, idle, idle, 1'b1, 1'b1);
        cyc(1'b1, idle, idle, 1'b1, 1'b1);
        cyc(1'b0, idle, idle, 1'b1, 1'b1);

        // Single m0 read of 0x8, response next cycle
        cyc(1'b0, mk(1, 0, 32'h8, 0, 4'hF), idle, 1'b1, 1'b1);
        cyc(1'b0, idle, idle, 1'b1, 1'b1);

        // Both masters read continuously: 4/4 alternation
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, mk(1, 0, 32'(i * 4), 0, 4'hF), mk(1, 0, 32'(64 + i * 4), 0, 4'hF),
                1'b1, 1'b1);
        end
        cyc(1'b0, idle, idle, 1'b1, 1'b1);

        // Back-to-back reads by different masters
        cyc(1'b0, mk(1, 0, 32'h0, 0, 4'hF), idle, 1'b1, 1'b1);
        cyc(1'b0, idle, mk(1, 0, 32'h4, 0, 4'hF), 1'b1, 1'b1);
        cyc(1'b0, idle, idle, 1'b1, 1'b1);

        // m1 write while m0 idle
        cyc(1'b0, idle, mk(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF), 1'b1, 1'b1);
        cyc(1'b0, idle, idle, 1'b1, 1'b1);

        // Slave stalls an m0 read for 3 cycles with m1 waiting
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, mk(1, 0, 32'h20, 0, 4'hF), mk(1, 0, 32'h30, 0, 4'hF), 1'b0, 1'b0);
        end
        cyc(1'b0, mk(1, 0, 32'h20, 0, 4'hF), mk(1, 0, 32'h30, 0, 4'hF), 1'b1, 1'b1);
        cyc(1'b0, idle, idle, 1'b1, 1'b1);

        // Reset lands right after a granted read; m0 wins afterwards
        cyc(1'b0, mk(1, 0, 32'h40, 0, 4'hF), idle, 1'b1, 1'b1);
        cyc(1'b1, mk(1, 0, 32'h44, 0, 4'hF), mk(1, 0, 32'h48, 0, 4'hF), 1'b1, 1'b1);
        cyc(1'b0, mk(1, 0, 32'h44, 0, 4'hF), mk(1, 0, 32'h48, 0, 4'hF), 1'b1, 1'b1);
        cyc(1'b0, idle, idle, 1'b1, 1'b1);

        // Random traffic with occasional stalls and resets
        for (int i = 0; i < 400; i++) begin
            mreq_t a, b;
            logic  r;
            a = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   32'($urandom_range(0, 63) * 4), $urandom, 4'($urandom));
            b = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   32'($urandom_range(0, 63) * 4), $urandom, 4'($urandom));
            r = ($urandom_range(0, 49) == 0);
            cyc(r, a, b, ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
